// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM, console TX FIFO with valid/ready drain, MMIO status.
// Optional cycle timer enabled by defining DMEM_TIMER_EN.
module dmem_responder #(
  parameter int DEPTH_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] REG_CONSOLE = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_TIMER   = 2'd2;

  logic               sel_mmio;
  logic [1:0]         reg_sel;
  logic [DEPTH_W-1:0] word_idx;
  logic               any_we;
  logic [3:0]         ram_we;
  logic               unused_addr;

  assign sel_mmio    = addr[31];
  assign reg_sel     = addr[3:2];
  assign word_idx    = addr[DEPTH_W+1:2];
  assign any_we      = |we;
  assign ram_we      = sel_mmio ? 4'b0000 : we;
  assign unused_addr = ^{addr[30:DEPTH_W+2], addr[1:0]};

  // RAM: asynchronous read, per-lane write, contents not reset.
  logic [31:0] mem [0:(1<<DEPTH_W)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Console FIFO
  logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty;
  logic          push_req, push_ok, pop, status_wr;
  logic [7:0]    push_byte;
  logic [4:0]    count5;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push_req  = sel_mmio && (reg_sel == REG_CONSOLE) && any_we;
  assign status_wr = sel_mmio && (reg_sel == REG_STATUS) && any_we;
  assign pop       = !empty && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req && (!full || pop);
  assign count5    = 5'(count_q);

  assign tx_valid  = !empty;
  assign tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr_q];

  always_comb begin
    push_byte = wdata[7:0];
    if (we[3])      push_byte = wdata[31:24];
    else if (we[2]) push_byte = wdata[23:16];
    else if (we[1]) push_byte = wdata[15:8];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (status_wr) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_byte;
  end

  // Cycle timer
  logic [31:0] timer_val;

`ifdef DMEM_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic        timer_wr;

  assign timer_wr = sel_mmio && (reg_sel == REG_TIMER) && any_we;

  // Clear has priority over the increment.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (timer_wr) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign timer_val = timer_q;
`else
  assign timer_val = '0;
`endif

  always_comb begin
    rdata = '0;
    if (!sel_mmio) begin
      rdata = mem[word_idx];
    end else begin
      case (reg_sel)
        REG_STATUS: rdata = {24'b0, count5, ovf_q, full, empty};
        REG_TIMER:  rdata = timer_val;
        default:    rdata = '0;
      endcase
    end
  end

endmodule
